// File: rtl/div_pkg.sv
// Shared types and constants for the iterative restoring divider.
package div_pkg;

  typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} div_state_t;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  // Every quotient bit is forced to this value on a divide-by-zero.
  function automatic logic div_zero_fill_bit();
    return 1'b1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring radix-2 step: shift in a dividend bit, trial-subtract the divisor.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // A set top bit means the shifted value exceeds 2^WIDTH, so the subtraction always fits.
  always_comb begin
    shifted = {rem_in[WIDTH-1:0], dividend_bit};
    trial   = shifted - {1'b0, divisor};
    q_bit   = rem_in[WIDTH] | ~trial[WIDTH];
    rem_out = q_bit ? trial : shifted;
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned integer divider: quotient and remainder in WIDTH+2 cycles.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CNT_W = (WIDTH == DIV_WIDTH) ? DIV_CNT_W : $clog2(WIDTH);

  div_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] in1_reg, in2_reg;
  logic             signed_reg;
  logic [WIDTH-1:0] a_mag_reg, b_mag_reg;
  logic             sign_q_reg, sign_r_reg;
  logic [WIDTH:0]   rem_reg;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH-1:0] q_out_reg, r_out_reg;
  logic             dz_out_reg;

  logic [WIDTH:0]   step_rem;
  logic             step_q;
  logic             s1, s2;
  logic [WIDTH-1:0] q_fix, r_fix;
  logic             dz_fix;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in       (rem_reg),
    .dividend_bit (a_mag_reg[cnt_reg]),
    .divisor      (b_mag_reg),
    .rem_out      (step_rem),
    .q_bit        (step_q)
  );

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = PREP;
      PREP:    state_next = ITER;
      ITER:    if (cnt_reg == '0) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    s1 = signed_reg & in1_reg[WIDTH-1];
    s2 = signed_reg & in2_reg[WIDTH-1];
  end

  // Overflow (-2^(W-1) / -1) needs no special case: magnitudes give 2^(W-1) with sign_q=0.
  always_comb begin
    dz_fix = (in2_reg == '0);
    q_fix  = sign_q_reg ? -quo_reg : quo_reg;
    r_fix  = sign_r_reg ? -rem_reg[WIDTH-1:0] : rem_reg[WIDTH-1:0];
    if (dz_fix) begin
      q_fix = {WIDTH{div_zero_fill_bit()}};
      r_fix = in1_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg    <= '0;
      in1_reg    <= '0;
      in2_reg    <= '0;
      signed_reg <= 1'b0;
      a_mag_reg  <= '0;
      b_mag_reg  <= '0;
      sign_q_reg <= 1'b0;
      sign_r_reg <= 1'b0;
      rem_reg    <= '0;
      quo_reg    <= '0;
      q_out_reg  <= '0;
      r_out_reg  <= '0;
      dz_out_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            in1_reg    <= in1;
            in2_reg    <= in2;
            signed_reg <= is_signed;
          end
        end
        PREP: begin
          a_mag_reg  <= s1 ? -in1_reg : in1_reg;
          b_mag_reg  <= s2 ? -in2_reg : in2_reg;
          sign_q_reg <= s1 ^ s2;
          sign_r_reg <= s1;
          rem_reg    <= '0;
          quo_reg    <= '0;
          cnt_reg    <= CNT_W'(WIDTH - 1);
        end
        ITER: begin
          rem_reg          <= step_rem;
          quo_reg[cnt_reg] <= step_q;
          cnt_reg          <= cnt_reg - CNT_W'(1);
        end
        FIX: begin
          q_out_reg  <= q_fix;
          r_out_reg  <= r_fix;
          dz_out_reg <= dz_fix;
        end
        default: ;
      endcase
    end
  end

  // Results are presented combinationally in FIX so they are valid together with done.
  always_comb begin
    busy      = (state_reg != IDLE);
    done      = (state_reg == FIX);
    quotient  = q_out_reg;
    remainder = r_out_reg;
    div_zero  = dz_out_reg;
    if (state_reg == FIX) begin
      quotient  = q_fix;
      remainder = r_fix;
      div_zero  = dz_fix;
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (WIDTH=32) using directed vectors.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] in1 = '0;
  logic [31:0] in2 = '0;
  logic [31:0] quotient, remainder;
  logic        busy, done, div_zero;

  int cyc = 0;
  int total = 0;
  int passed = 0;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          cyc;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  seq_divider #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .in1       (in1),
    .in2       (in2),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", name, got, exp);
  endtask

  // Monitor: every done pulse must match the oldest expected result, including its cycle.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_done: got done at cycle %0d, required none", cyc);
      end else begin
        e = exp_q.pop_front();
        chk({e.name, "_cycle"}, cyc, e.cyc);
        chk({e.name, "_q"}, quotient, e.q);
        chk({e.name, "_r"}, remainder, e.r);
        chk({e.name, "_dz"}, {31'd0, div_zero}, {31'd0, e.dz});
        $display("op %s: cycle %0d q=0x%08h r=0x%08h dz=%0b", e.name, cyc, quotient, remainder, div_zero);
      end
    end
  end

  // Drives one start cycle; returns at the following negedge with start low.
  task automatic issue(input string name, input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er, input logic edz,
                       input bit push, output int n);
    exp_t x;
    @(negedge clk);
    is_signed = s;
    in1 = a;
    in2 = b;
    start = 1'b1;
    n = cyc;
    if (push) begin
      x.q = eq; x.r = er; x.dz = edz; x.cyc = n + 34; x.name = name;
      exp_q.push_back(x);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 80) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      total++;
      $display("FAIL %s_timeout: got %0d pending results, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    int n;
    exp_t x;
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_q", quotient, 32'd0);
    chk("reset_r", remainder, 32'd0);
    chk("reset_dz", {31'd0, div_zero}, 32'd0);
    rst = 1'b0;

    // Unsigned 100/7 with busy tracked across the whole op.
    issue("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1, n);
    for (int k = 1; k <= 35; k++) begin
      chk($sformatf("busy_c%0d", k), {31'd0, busy}, (k <= 34) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    wait_done("u100_7");

    issue("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b1, n);
    wait_done("s_m7_2");
    issue("u_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 1'b0, 1'b1, n);
    wait_done("u_m7_2");
    issue("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b1, n);
    wait_done("s_7_m2");
    issue("s_m7_m2", 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 1'b0, 1'b1, n);
    wait_done("s_m7_m2");
    issue("u5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b1, n);
    wait_done("u5_0");
    issue("s5_0", 1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b1, n);
    wait_done("s5_0");
    issue("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b1, n);
    wait_done("s_ovf");

    // Back to back: a start while busy and a start during done are both ignored.
    issue("u10_3", 1'b0, 32'd10, 32'd3, 32'd3, 32'd1, 1'b0, 1'b1, n);
    while (cyc < n + 10) @(negedge clk);
    start = 1'b1; in1 = 32'd50; in2 = 32'd5;
    @(negedge clk);
    start = 1'b0;
    while (cyc < n + 34) @(negedge clk);
    start = 1'b1; in1 = 32'd50; in2 = 32'd5;
    @(negedge clk);
    x.q = 32'd10; x.r = 32'd0; x.dz = 1'b0; x.cyc = cyc + 34; x.name = "u50_5";
    exp_q.push_back(x);
    @(negedge clk);
    start = 1'b0;
    wait_done("u50_5");

    // Reset mid-operation: no result expected for the aborted op.
    issue("abort", 1'b0, 32'd123, 32'd4, 32'd0, 32'd0, 1'b0, 1'b0, n);
    while (cyc < n + 15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_q", quotient, 32'd0);
    chk("abort_r", remainder, 32'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    issue("u9_4", 1'b0, 32'd9, 32'd4, 32'd2, 32'd1, 1'b0, 1'b1, n);
    wait_done("u9_4");

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
